// File: rtl/entry_pkg.sv
// Shared types and constants for the switch-driven operand loader.
// Provides the loader state enum, a constant-friendly clog2 and the default debounce window.
package entry_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        CTRL = 2'd2
    } state_e;

    localparam int DEF_CNT_MAX = 500_000;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchroniser, stability counter and level edge pulses.
// The level only follows the synchronised input after it has been steady for CNT_MAX clocks.
module sw_debounce
    import entry_pkg::*;
#(
    parameter int CNT_MAX = DEF_CNT_MAX,
    parameter int CNT_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state for synchroniser, stability counter and debounced level.
    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev_q;
    assign fall  = ~level_q & level_prev_q;

endmodule

// File: rtl/operand_entry.sv
// Switch-driven operand loader: commits CHUNK-bit slices into NOPS operands with undo and FULL.
// Optional CLEAR_ON_ENTER_EN zeroes all operands when leaving CTRL back into LOAD.
module operand_entry
    import entry_pkg::*;
#(
    parameter int OPW     = 16,
    parameter int CHUNK   = 8,
    parameter int NOPS    = 2,
    parameter int CNT_MAX = DEF_CNT_MAX,
    parameter int CNT_W   = 20,
    localparam int CHUNKS = OPW / CHUNK,
    localparam int PHASES = NOPS * CHUNKS,
    localparam int PW     = (clog2(PHASES) < 1) ? 1 : clog2(PHASES)
) (
    input  logic                CLOCK_50,
    input  logic                rst,
    input  logic                mode_raw,
    input  logic                commit_raw,
    input  logic                undo_raw,
    input  logic [CHUNK-1:0]    data_in,
    output logic [NOPS*OPW-1:0] operands,
    output logic [PW-1:0]       phase,
    output logic [PHASES-1:0]   phase_oh,
    output logic                mode_ctrl,
    output logic                full,
    output logic                load_done
);

    localparam logic [PW-1:0] PH_LAST = PW'(PHASES - 1);

    logic mode_rise_s, mode_fall_s, commit_rise_s, undo_rise_s;
    logic commit_fall_s, undo_fall_s, commit_lvl_s, undo_lvl_s;
    logic unused_sw_s;

    sw_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) u_mode_db (
        .clk(CLOCK_50), .rst(rst), .raw(mode_raw),
        .level(mode_ctrl), .rise(mode_rise_s), .fall(mode_fall_s)
    );
    sw_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) u_commit_db (
        .clk(CLOCK_50), .rst(rst), .raw(commit_raw),
        .level(commit_lvl_s), .rise(commit_rise_s), .fall(commit_fall_s)
    );
    sw_debounce #(.CNT_MAX(CNT_MAX), .CNT_W(CNT_W)) u_undo_db (
        .clk(CLOCK_50), .rst(rst), .raw(undo_raw),
        .level(undo_lvl_s), .rise(undo_rise_s), .fall(undo_fall_s)
    );

    assign unused_sw_s = commit_fall_s ^ undo_fall_s ^ commit_lvl_s ^ undo_lvl_s;

    logic commit_p_s, undo_p_s;
    assign commit_p_s = commit_rise_s & ~mode_ctrl;
    assign undo_p_s   = undo_rise_s & ~mode_ctrl;

    state_e               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [NOPS*OPW-1:0]  operands_q, operands_d;
    logic                 load_done_q, load_done_d;

    // Loader FSM: mode edges take priority, commit and undo together cancel each other.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        operands_d  = operands_q;
        load_done_d = 1'b0;
        if (mode_rise_s) begin
            state_d = CTRL;
        end else begin
            case (state_q)
                CTRL: begin
                    if (mode_fall_s) begin
                        state_d = LOAD;
                        phase_d = '0;
`ifdef CLEAR_ON_ENTER_EN
                        operands_d = '0;
`else
                        operands_d = operands_q;
`endif
                    end else begin
                        state_d = CTRL;
                    end
                end
                LOAD: begin
                    if (commit_p_s && !undo_p_s) begin
                        operands_d[int'(phase_q)*CHUNK +: CHUNK] = data_in;
                        if (phase_q == PH_LAST) begin
                            state_d     = FULL;
                            load_done_d = 1'b1;
                        end else begin
                            phase_d = phase_q + PW'(1);
                        end
                    end else if (undo_p_s && !commit_p_s && (phase_q != '0)) begin
                        phase_d = phase_q - PW'(1);
                    end else begin
                        state_d = LOAD;
                    end
                end
                FULL: begin
                    if (undo_p_s && !commit_p_s) begin
                        state_d = LOAD;
                        phase_d = PH_LAST;
                    end else begin
                        state_d = FULL;
                    end
                end
                default: begin
                    state_d = LOAD;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Loader state, phase, operand array and completion strobe.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            phase_q     <= '0;
            operands_q  <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            operands_q  <= operands_d;
            load_done_q <= load_done_d;
        end
    end

    // LED decode: phase 0 lights the MSB.
    always_comb begin
        phase_oh = '0;
        for (int i = 0; i < PHASES; i++) begin
            phase_oh[PHASES-1-i] = (int'(phase_q) == i);
        end
    end

    assign operands  = operands_q;
    assign phase     = phase_q;
    assign full      = (state_q == FULL);
    assign load_done = load_done_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: per-cycle comparison against a behavioural model
// plus directed literal expectations for each scenario.
module tb_operand_entry;

    localparam int OPW     = 16;
    localparam int CHUNK   = 8;
    localparam int NOPS    = 2;
    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;
    localparam int PHASES  = 4;
    localparam int PW      = 2;
    localparam int HL      = CNT_MAX + 2;
    localparam int M_LOAD  = 0;
    localparam int M_FULL  = 1;
    localparam int M_CTRL  = 2;

    logic                CLOCK_50   = 1'b0;
    logic                rst        = 1'b1;
    logic                mode_raw   = 1'b0;
    logic                commit_raw = 1'b0;
    logic                undo_raw   = 1'b0;
    logic [CHUNK-1:0]    data_in    = 8'h00;
    logic [NOPS*OPW-1:0] operands;
    logic [PW-1:0]       phase;
    logic [PHASES-1:0]   phase_oh;
    logic                mode_ctrl;
    logic                full;
    logic                load_done;

    operand_entry #(
        .OPW(OPW), .CHUNK(CHUNK), .NOPS(NOPS), .CNT_MAX(CNT_MAX), .CNT_W(CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50), .rst(rst), .mode_raw(mode_raw), .commit_raw(commit_raw),
        .undo_raw(undo_raw), .data_in(data_in), .operands(operands), .phase(phase),
        .phase_oh(phase_oh), .mode_ctrl(mode_ctrl), .full(full), .load_done(load_done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_state = M_LOAD;
    int         m_phase = 0;
    logic [7:0] m_chunk [PHASES];
    logic       m_done  = 1'b0;
    bit         m_lvl   [3];
    bit         m_rise  [3];
    bit         m_fall  [3];
    bit         m_hist  [3][HL];

    function automatic logic [31:0] m_operands();
        logic [31:0] v;
        for (int i = 0; i < PHASES; i++) v[i*8 +: 8] = m_chunk[i];
        return v;
    endfunction

    function automatic logic [PHASES-1:0] m_oh();
        logic [PHASES-1:0] v;
        v = '0;
        v[PHASES-1-m_phase] = 1'b1;
        return v;
    endfunction

    task automatic m_clear();
        m_state = M_LOAD;
        m_phase = 0;
        m_done  = 1'b0;
        for (int i = 0; i < PHASES; i++) m_chunk[i] = 8'h00;
        for (int s = 0; s < 3; s++) begin
            m_lvl[s] = 0; m_rise[s] = 0; m_fall[s] = 0;
            for (int k = 0; k < HL; k++) m_hist[s][k] = 0;
        end
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge CLOCK_50 or posedge rst);
            if (rst) begin
                m_clear();
            end else begin
                bit cp, up, stable;
                bit raws [3];
                cp = m_rise[1] && !m_lvl[0];
                up = m_rise[2] && !m_lvl[0];
                m_done = 1'b0;
                if (m_rise[0]) m_state = M_CTRL;
                else if (m_state == M_CTRL) begin
                    if (m_fall[0]) begin
                        m_state = M_LOAD;
                        m_phase = 0;
`ifdef CLEAR_ON_ENTER_EN
                        for (int i = 0; i < PHASES; i++) m_chunk[i] = 8'h00;
`endif
                    end
                end
                else if (cp && up) begin end
                else if (m_state == M_LOAD && cp) begin
                    m_chunk[m_phase] = data_in;
                    if (m_phase == PHASES - 1) begin
                        m_state = M_FULL;
                        m_done  = 1'b1;
                    end else m_phase++;
                end
                else if (m_state == M_LOAD && up) begin
                    if (m_phase > 0) m_phase--;
                end
                else if (m_state == M_FULL && up) begin
                    m_state = M_LOAD;
                    m_phase = PHASES - 1;
                end
                // a switch level flips once the raw value has differed for CNT_MAX samples, 2 syncs ago
                raws[0] = mode_raw; raws[1] = commit_raw; raws[2] = undo_raw;
                for (int s = 0; s < 3; s++) begin
                    for (int k = HL - 1; k > 0; k--) m_hist[s][k] = m_hist[s][k-1];
                    m_hist[s][0] = raws[s];
                    stable = 1;
                    for (int k = 2; k < HL; k++) if (m_hist[s][k] == m_lvl[s]) stable = 0;
                    m_rise[s] = 0; m_fall[s] = 0;
                    if (stable) begin
                        m_lvl[s]  = !m_lvl[s];
                        m_rise[s] = m_lvl[s];
                        m_fall[s] = !m_lvl[s];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLOCK_50) begin
        if (!rst) begin
            chk("cmp_operands", 64'(operands), 64'(m_operands()));
            chk("cmp_phase", 64'(phase), 64'(m_phase));
            chk("cmp_phase_oh", 64'(phase_oh), 64'(m_oh()));
            chk("cmp_mode_ctrl", 64'(mode_ctrl), 64'(m_lvl[0]));
            chk("cmp_full", 64'(full), 64'(m_state == M_FULL));
            chk("cmp_load_done", 64'(load_done), 64'(m_done));
            if (load_done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic press_commit(input logic [7:0] v);
        data_in    = v;
        commit_raw = 1'b1;
        tick(CNT_MAX + 4);
        commit_raw = 1'b0;
        tick(CNT_MAX + 4);
    endtask

    task automatic press_undo();
        undo_raw = 1'b1;
        tick(CNT_MAX + 4);
        undo_raw = 1'b0;
        tick(CNT_MAX + 4);
    endtask

    task automatic set_mode(input logic v);
        mode_raw = v;
        tick(CNT_MAX + 5);
    endtask

    initial begin
        // 1. reset state and a full load
        tick(3);
        chk("rst_operands", 64'(operands), 64'h0);
        chk("rst_phase", 64'(phase), 64'h0);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_load_done", 64'(load_done), 64'h0);
        chk("rst_mode_ctrl", 64'(mode_ctrl), 64'h0);
        rst = 1'b0;
        tick(1);
        chk("rst_phase_oh", 64'(phase_oh), 64'h8);
        press_commit(8'h34);
        press_commit(8'h12);
        press_commit(8'h78);
        chk("t1_phase3", 64'(phase), 64'h3);
        chk("t1_not_full", 64'(full), 64'h0);
        done_cnt = 0;
        press_commit(8'h56);
        chk("t1_operands", 64'(operands), 64'h5678_1234);
        chk("t1_full", 64'(full), 64'h1);
        chk("t1_phase_stays", 64'(phase), 64'h3);
        chk("t1_done_pulses", 64'(done_cnt), 64'h1);

        // 2. short glitch on commit is rejected
        do_reset();
        press_commit(8'h11);
        data_in    = 8'hEE;
        commit_raw = 1'b1;
        tick(2);
        commit_raw = 1'b0;
        tick(CNT_MAX + 6);
        chk("t2_phase", 64'(phase), 64'h1);
        chk("t2_operands", 64'(operands), 64'h0000_0011);

        // 3. undo overwrites; undo at phase 0 is ignored; commit+undo together ignored
        do_reset();
        press_commit(8'hAA);
        press_commit(8'hBB);
        press_undo();
        chk("t3_phase_after_undo", 64'(phase), 64'h1);
        press_commit(8'hCC);
        chk("t3_operands", 64'(operands), 64'h0000_CCAA);
        chk("t3_phase", 64'(phase), 64'h2);
        press_undo();
        press_undo();
        press_undo();
        chk("t3_phase_floor", 64'(phase), 64'h0);
        data_in    = 8'h77;
        commit_raw = 1'b1;
        undo_raw   = 1'b1;
        tick(CNT_MAX + 4);
        commit_raw = 1'b0;
        undo_raw   = 1'b0;
        tick(CNT_MAX + 4);
        chk("t3_both_phase", 64'(phase), 64'h0);
        chk("t3_both_operands", 64'(operands), 64'h0000_CCAA);

        // 4. FULL behaviour
        press_commit(8'h01);
        press_commit(8'h02);
        press_commit(8'h03);
        press_commit(8'h04);
        chk("t4_full", 64'(full), 64'h1);
        press_commit(8'hFF);
        chk("t4_ignored", 64'(operands), 64'h0403_0201);
        press_undo();
        chk("t4_undo_phase", 64'(phase), 64'h3);
        chk("t4_undo_full", 64'(full), 64'h0);
        done_cnt = 0;
        press_commit(8'h99);
        chk("t4_operands", 64'(operands), 64'h9903_0201);
        chk("t4_refull", 64'(full), 64'h1);
        chk("t4_done_pulses", 64'(done_cnt), 64'h1);

        // 5. CTRL mode blocks commits; return resets phase
        set_mode(1'b1);
        chk("t5_mode_ctrl", 64'(mode_ctrl), 64'h1);
        chk("t5_ctrl_not_full", 64'(full), 64'h0);
        press_commit(8'h55);
        chk("t5_no_write", 64'(operands), 64'h9903_0201);
        set_mode(1'b0);
        chk("t5_phase0", 64'(phase), 64'h0);
        chk("t5_mode_data", 64'(mode_ctrl), 64'h0);
`ifdef CLEAR_ON_ENTER_EN
        chk("t5_operands", 64'(operands), 64'h0);
`else
        chk("t5_operands", 64'(operands), 64'h9903_0201);
`endif

        // 6. async reset mid-load acts without a clock
        do_reset();
        press_commit(8'h11);
        press_commit(8'h22);
        chk("t6_before", 64'(operands), 64'h0000_2211);
        @(posedge CLOCK_50);
        #2 rst = 1'b1;
        #1;
        chk("t6_operands", 64'(operands), 64'h0);
        chk("t6_phase", 64'(phase), 64'h0);
        chk("t6_full", 64'(full), 64'h0);
        tick(2);
        rst = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
